// File: rtl/gppcu_instr_feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gppcu_instr_feeder_pkg : shared GPPCU widths, feeder FSM encoding, helpers |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package gppcu_instr_feeder_pkg;

  localparam int c_GPPCU_DBW = 32;

  typedef enum logic [0:0] {
    FEED_IDLE = 1'b0,
    FEED_RUN  = 1'b1
  } feed_state_e;

  // A new read may issue only if it still fits in the 2-entry FIFO, once this
  // cycle's pop has been credited back.
  function automatic logic credit_ok(input logic [1:0] occ,
                                     input logic       inflight,
                                     input logic       pop);
    logic [2:0] w_sum;
    w_sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return (w_sum < 3'd2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gppcu_skid_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gppcu_skid_fifo : 2-entry output FIFO, head drives the instruction port    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module gppcu_skid_fifo
  import gppcu_instr_feeder_pkg::*;
#(
  parameter int DBW = c_GPPCU_DBW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_push,
  input  logic [DBW-1:0] i_data,
  input  logic           i_pop,
  input  logic           i_flush,
  output logic [DBW-1:0] o_data,
  output logic           o_valid,
  output logic [1:0]     o_count
);

  logic [DBW-1:0] r_data [2];
  logic           r_rd_ptr;
  logic           r_wr_ptr;
  logic [1:0]     r_count;
  logic           w_do_pop;
  logic           w_do_push;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_data[r_wr_ptr] <= i_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign o_data  = r_data[r_rd_ptr];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/gppcu_instr_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gppcu_instr_feeder : streams a program-memory window to the core           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module gppcu_instr_feeder
  import gppcu_instr_feeder_pkg::*;
#(
  parameter int DBW = c_GPPCU_DBW,
  parameter int PBW = 8
) (
  input  logic           iACLK,
  input  logic           inRST,
  input  logic           iHOST_WR,
  input  logic [PBW-1:0] iHOST_ADDR,
  input  logic [DBW-1:0] iHOST_WDATA,
  input  logic           iSTART,
  input  logic [PBW-1:0] iSTART_ADDR,
  input  logic [PBW:0]   iCOUNT,
  input  logic           iABORT,
  output logic           oBUSY,
  output logic           oDONE,
  output logic [DBW-1:0] oINSTR,
  output logic           oINSTR_VALID,
  input  logic           iINSTR_READY
);

  localparam int           c_DEPTH     = 1 << PBW;
  localparam logic [PBW:0] c_MAX_COUNT = {1'b1, {PBW{1'b0}}};

  feed_state_e    r_state;
  feed_state_e    w_state_nxt;
  logic [PBW-1:0] r_pc;
  logic [PBW-1:0] w_pc_nxt;
  logic [PBW:0]   r_rem;
  logic [PBW:0]   w_rem_nxt;
  logic           r_done;
  logic           w_done_nxt;
  logic           r_rd_valid;
  logic           w_rd_en;
  logic [PBW-1:0] w_rd_addr;
  logic           w_flush;
  logic           w_pop;
  logic           w_host_we;
  logic           w_last_drain;
  logic [PBW:0]   w_count_clamped;
  logic [1:0]     w_fifo_count;
  logic           w_fifo_valid;

  logic [DBW-1:0] r_mem [c_DEPTH];
  logic [DBW-1:0] r_rd_data;
  logic [DBW-1:0] r_byp_data;
  logic           r_byp;
  logic [DBW-1:0] w_rd_word;

  assign w_host_we       = iHOST_WR && (r_state == FEED_IDLE);
  assign w_count_clamped = (iCOUNT > c_MAX_COUNT) ? c_MAX_COUNT : iCOUNT;
  assign w_pop           = w_fifo_valid && iINSTR_READY;
  // The last entry leaves the FIFO this cycle (or it is already empty).
  assign w_last_drain    = (w_fifo_count == 2'd0) ||
                           ((w_fifo_count == 2'd1) && w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_rem_nxt   = r_rem;
    w_done_nxt  = 1'b0;
    w_rd_en     = 1'b0;
    w_rd_addr   = r_pc;
    w_flush     = 1'b0;
    case (r_state)
      FEED_IDLE: begin
        if (iSTART) begin
          if (w_count_clamped == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            // First read issues in the start cycle so data is valid at start+2.
            w_state_nxt = FEED_RUN;
            w_rd_en     = 1'b1;
            w_rd_addr   = iSTART_ADDR;
            w_pc_nxt    = iSTART_ADDR + PBW'(1);
            w_rem_nxt   = w_count_clamped - (PBW+1)'(1);
          end
        end
      end
      FEED_RUN: begin
        if (iABORT) begin
          w_flush     = 1'b1;
          w_state_nxt = FEED_IDLE;
          w_rem_nxt   = '0;
        end else if (r_rem != '0) begin
          if (credit_ok(w_fifo_count, r_rd_valid, w_pop)) begin
            w_rd_en   = 1'b1;
            w_pc_nxt  = r_pc + PBW'(1);
            w_rem_nxt = r_rem - (PBW+1)'(1);
          end
        end else if (!r_rd_valid && w_last_drain) begin
          w_state_nxt = FEED_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = FEED_IDLE;
    endcase
  end

  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      r_state    <= FEED_IDLE;
      r_pc       <= '0;
      r_rem      <= '0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_rem      <= w_rem_nxt;
      r_done     <= w_done_nxt;
      r_rd_valid <= w_rd_en;
    end
  end

  // Program memory is not reset; a same-cycle host write to the read address
  // is forwarded so a run started together with that write sees the new word.
  always_ff @(posedge iACLK) begin
    if (w_host_we) begin
      r_mem[iHOST_ADDR] <= iHOST_WDATA;
    end
    if (w_rd_en) begin
      r_rd_data  <= r_mem[w_rd_addr];
      r_byp      <= w_host_we && (iHOST_ADDR == w_rd_addr);
      r_byp_data <= iHOST_WDATA;
    end
  end

  assign w_rd_word = r_byp ? r_byp_data : r_rd_data;

  gppcu_skid_fifo #(
    .DBW(DBW)
  ) u_fifo (
    .clk     (iACLK),
    .rst_n   (inRST),
    .i_push  (r_rd_valid),
    .i_data  (w_rd_word),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (oINSTR),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign oINSTR_VALID = w_fifo_valid;
  assign oBUSY        = (r_state == FEED_RUN);
  assign oDONE        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_gppcu_instr_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gppcu_instr_feeder : scoreboard bench for the instruction feeder        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_gppcu_instr_feeder;

  localparam int DBW = 32;
  localparam int PBW = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           iHOST_WR = 1'b0;
  logic [PBW-1:0] iHOST_ADDR = '0;
  logic [DBW-1:0] iHOST_WDATA = '0;
  logic           iSTART = 1'b0;
  logic [PBW-1:0] iSTART_ADDR = '0;
  logic [PBW:0]   iCOUNT = '0;
  logic           iABORT = 1'b0;
  logic           iINSTR_READY = 1'b1;
  logic           oBUSY;
  logic           oDONE;
  logic [DBW-1:0] oINSTR;
  logic           oINSTR_VALID;

  int n_chk  = 0;
  int n_fail = 0;
  int n_hs   = 0;
  int n_done = 0;
  logic [DBW-1:0] exp_q [$];

  always #5 clk = ~clk;

  gppcu_instr_feeder #(.DBW(DBW), .PBW(PBW)) dut (
    .iACLK        (clk),
    .inRST        (rst_n),
    .iHOST_WR     (iHOST_WR),
    .iHOST_ADDR   (iHOST_ADDR),
    .iHOST_WDATA  (iHOST_WDATA),
    .iSTART       (iSTART),
    .iSTART_ADDR  (iSTART_ADDR),
    .iCOUNT       (iCOUNT),
    .iABORT       (iABORT),
    .oBUSY        (oBUSY),
    .oDONE        (oDONE),
    .oINSTR       (oINSTR),
    .oINSTR_VALID (oINSTR_VALID),
    .iINSTR_READY (iINSTR_READY)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold under stall.
  logic           stall_prev = 1'b0;
  logic [DBW-1:0] instr_prev = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", oINSTR_VALID, 1);
        chk("hold_data", oINSTR, instr_prev);
      end
      if (oINSTR_VALID && iINSTR_READY) begin
        n_hs++;
        chk("xfer_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("xfer_data", oINSTR, exp_q.pop_front());
      end
      if (oDONE) n_done++;
      stall_prev = oINSTR_VALID && !iINSTR_READY;
      instr_prev = oINSTR;
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [PBW-1:0] a, input logic [DBW-1:0] d);
    iHOST_WR = 1'b1; iHOST_ADDR = a; iHOST_WDATA = d;
    next_cyc();
    iHOST_WR = 1'b0;
  endtask

  task automatic start_run(input logic [PBW-1:0] a, input logic [PBW:0] n);
    iSTART = 1'b1; iSTART_ADDR = a; iCOUNT = n;
    next_cyc();
    iSTART = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int max_cyc);
    bit seen = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (oDONE) seen = 1;
    end
    chk(nm, seen, 1);
    next_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    int hs0;
    int dn0;
    // ---------------- reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", oBUSY, 0);
    chk("rst_done", oDONE, 0);
    chk("rst_valid", oINSTR_VALID, 0);
    chk("rst_instr", oINSTR, 0);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();

    // ---------------- full-rate run
    for (int i = 0; i < 4; i++) host_write(PBW'(i), 32'h10 + i);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h10 + i);
    hs0 = n_hs;
    start_run(8'd0, 9'd4);                       // now in cycle 1
    @(negedge clk);
    chk("fr_c1_valid_low", oINSTR_VALID, 0);
    chk("fr_c1_busy", oBUSY, 1);
    for (int c = 2; c <= 5; c++) begin
      next_cyc();
      @(negedge clk);
      chk("fr_valid_each_cycle", oINSTR_VALID, 1);
      chk("fr_done_early", oDONE, 0);
    end
    next_cyc();
    @(negedge clk);
    chk("fr_done_pulse", oDONE, 1);
    chk("fr_busy_fall", oBUSY, 0);
    chk("fr_xfers", n_hs - hs0, 4);
    chk("fr_queue_empty", exp_q.size(), 0);
    next_cyc();
    @(negedge clk);
    chk("fr_done_one_cycle", oDONE, 0);
    next_cyc();

    // ---------------- backpressure: READY low in cycles 3..6
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h10 + i);
    hs0 = n_hs;
    start_run(8'd0, 9'd4);                       // cycle 1
    next_cyc();                                  // cycle 2
    next_cyc();                                  // cycle 3
    iINSTR_READY = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      chk("bp_held_instr", oINSTR, 32'h11);
      next_cyc();
    end
    iINSTR_READY = 1'b1;
    wait_done("bp_done_seen", 20);
    chk("bp_xfers", n_hs - hs0, 4);
    chk("bp_queue_empty", exp_q.size(), 0);

    // ---------------- zero count
    hs0 = n_hs;
    start_run(8'd0, 9'd0);
    @(negedge clk);
    chk("zc_done", oDONE, 1);
    chk("zc_busy", oBUSY, 0);
    chk("zc_valid", oINSTR_VALID, 0);
    next_cyc();
    @(negedge clk);
    chk("zc_done_one_cycle", oDONE, 0);
    chk("zc_no_xfer", n_hs - hs0, 0);
    next_cyc();

    // ---------------- host write coincident with start
    exp_q.push_back(32'h99);
    iHOST_WR = 1'b1; iHOST_ADDR = 8'd9; iHOST_WDATA = 32'h99;
    start_run(8'd9, 9'd1);
    iHOST_WR = 1'b0;
    wait_done("coinc_done_seen", 20);
    chk("coinc_queue_empty", exp_q.size(), 0);

    // ---------------- start and host write during RUN are ignored
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h10 + i);
    hs0 = n_hs;
    start_run(8'd0, 9'd4);                       // cycle 1
    iSTART = 1'b1; iSTART_ADDR = 8'd2; iCOUNT = 9'd2;
    iHOST_WR = 1'b1; iHOST_ADDR = 8'd3; iHOST_WDATA = 32'hDEAD;
    next_cyc();
    iSTART = 1'b0; iHOST_WR = 1'b0;
    wait_done("busy_done_seen", 20);
    repeat (2) next_cyc();
    @(negedge clk);
    chk("busy_ign_idle_after", oBUSY, 0);
    chk("busy_xfers", n_hs - hs0, 4);
    next_cyc();
    exp_q.push_back(32'h13);
    start_run(8'd3, 9'd1);
    wait_done("busy_rerun_done", 20);
    chk("busy_mem_unchanged", exp_q.size(), 0);

    // ---------------- wrap-around 254,255,0,1
    host_write(8'd254, 32'hA0);
    host_write(8'd255, 32'hA1);
    host_write(8'd0, 32'hA2);
    host_write(8'd1, 32'hA3);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
    hs0 = n_hs;
    start_run(8'd254, 9'd4);
    wait_done("wrap_done_seen", 20);
    chk("wrap_xfers", n_hs - hs0, 4);
    chk("wrap_queue_empty", exp_q.size(), 0);

    // ---------------- abort after the 3rd handshake
    for (int i = 0; i < 8; i++) host_write(PBW'(i), 32'h20 + i);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h20 + i);
    hs0 = n_hs;
    dn0 = n_done;
    start_run(8'd0, 9'd8);                       // cycle 1
    repeat (4) next_cyc();                       // cycle 5
    iABORT = 1'b1;
    next_cyc();
    iABORT = 1'b0;
    @(negedge clk);
    chk("ab_valid_low", oINSTR_VALID, 0);
    chk("ab_busy_low", oBUSY, 0);
    chk("ab_no_done", oDONE, 0);
    chk("ab_xfers", n_hs - hs0, 4);
    chk("ab_queue_empty", exp_q.size(), 0);
    repeat (3) next_cyc();
    chk("ab_never_done", n_done - dn0, 0);
    exp_q.push_back(32'h25);
    exp_q.push_back(32'h26);
    start_run(8'd5, 9'd2);
    wait_done("ab_restart_done", 20);
    chk("ab_restart_queue_empty", exp_q.size(), 0);

    // ---------------- asynchronous reset mid-run
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h21);
    start_run(8'd0, 9'd4);                       // cycle 1
    repeat (2) next_cyc();                       // cycle 3
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", oINSTR_VALID, 0);
    chk("ar_busy", oBUSY, 0);
    chk("ar_instr", oINSTR, 0);
    chk("ar_done", oDONE, 0);
    chk("ar_queue_empty", exp_q.size(), 0);
    repeat (2) next_cyc();
    rst_n = 1'b1;
    dn0 = n_done;
    repeat (4) next_cyc();
    chk("ar_no_done_after", n_done - dn0, 0);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h20 + i);
    start_run(8'd0, 9'd4);
    wait_done("ar_rerun_done", 20);
    chk("ar_mem_intact", exp_q.size(), 0);

    // ---------------- count clamp: 0x1FF -> 256 instructions from 0x80
    for (int i = 0; i < 256; i++) host_write(PBW'(i), 32'hC000_0000 | i);
    for (int k = 0; k < 256; k++) exp_q.push_back(32'hC000_0000 | ((k + 128) & 255));
    hs0 = n_hs;
    start_run(8'd128, 9'h1FF);
    wait_done("clamp_done_seen", 400);
    chk("clamp_xfers", n_hs - hs0, 256);
    chk("clamp_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
